// File: rtl/router_pkg.sv
// router_pkg: shared router constants (byte width, FIFO depth, header field positions).
package router_pkg;
  localparam int WIDTH       = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int ADDR_MSB    = 1;
  localparam int ADDR_LSB    = 0;
  localparam int PARITY_CNT  = 1;
endpackage

// File: rtl/router_fifo_if.sv
// router_fifo_if: write/read handshake and status bundle of one router output FIFO.
interface router_fifo_if #(parameter int WIDTH = 8) ();
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  modport master (output soft_reset, write_enb, read_enb, lfd_state, data_in,
                  input data_out, empty, full);
  modport slave  (input soft_reset, write_enb, read_enb, lfd_state, data_in,
                  output data_out, empty, full);
endinterface

// File: rtl/router_fifo_ptr.sv
// router_fifo_ptr: wrap-bit read/write pointer pair with full/empty and gated strobes.
module router_fifo_ptr #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic        i_rd,
  output logic [AW:0] o_wr_ptr,
  output logic [AW:0] o_rd_ptr,
  output logic        o_do_wr,
  output logic        o_do_rd,
  output logic        o_empty,
  output logic        o_full
);
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_empty  = r_wr_ptr == r_rd_ptr;
  assign o_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_do_wr  = i_wr && !o_full;
  assign o_do_rd  = i_rd && !o_empty;
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (o_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer with header-driven packet counter; ROUTER_FIFO_OVF_EN adds sticky ovf_err.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = router_pkg::WIDTH,
  parameter int AW    = 4
) (
  input logic            clk,
  input logic            reset,
  router_fifo_if.slave   b
`ifdef ROUTER_FIFO_OVF_EN
  , output logic         ovf_err
`endif
);
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [WIDTH-1:0] r_data_out;
  logic [6:0]       r_pkt_cnt;
  logic [AW:0]      w_wr_ptr, w_rd_ptr;
  logic             w_do_wr, w_do_rd, w_clr;
  logic [WIDTH:0]   w_rd_entry;
  logic [6:0]       w_next_cnt;
  assign w_clr      = b.soft_reset;
  assign w_rd_entry = r_mem[w_rd_ptr[AW-1:0]];
  assign b.data_out = r_data_out;
  router_fifo_ptr #(.AW(AW)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_wr     (b.write_enb),
    .i_rd     (b.read_enb),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_do_wr  (w_do_wr),
    .o_do_rd  (w_do_rd),
    .o_empty  (b.empty),
    .o_full   (b.full)
  );
  // A header reloads the count with payload length plus the trailing parity byte
  always_comb begin
    w_next_cnt = w_rd_entry[WIDTH] ? 7'(w_rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]) + 7'(PARITY_CNT)
               : (r_pkt_cnt != 7'd0 ? r_pkt_cnt - 7'd1 : 7'd0);
  end
  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_data_out <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_do_wr) r_mem[w_wr_ptr[AW-1:0]] <= {b.lfd_state, b.data_in};
      if (w_do_rd) begin
        r_data_out <= w_rd_entry[WIDTH-1:0];
        r_pkt_cnt  <= w_next_cnt;
      end else if (r_pkt_cnt == 7'd0) begin
        r_data_out <= '0;
      end
    end
  end
`ifdef ROUTER_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (reset || w_clr) ovf_err <= 1'b0;
    else if (b.write_enb && b.full && !b.read_enb) ovf_err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: scoreboard bench for router_fifo; covers ovf_err when ROUTER_FIFO_OVF_EN is defined.
module tb_router_fifo;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];
  int m_pkt;
  logic [7:0] m_dout;
  logic m_ovf;
  router_fifo_if #(.WIDTH(8)) bus ();
`ifdef ROUTER_FIFO_OVF_EN
  logic ovf;
`endif
  router_fifo dut (
    .clk   (clk),
    .reset (reset),
    .b     (bus)
`ifdef ROUTER_FIFO_OVF_EN
    , .ovf_err (ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic rs, input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] d);
    logic do_wr, do_rd;
    logic [8:0] e;
    reset = rs; bus.soft_reset = sr; bus.write_enb = we; bus.read_enb = re;
    bus.lfd_state = lfd; bus.data_in = d;
    if (rs || sr) begin
      q.delete(); m_pkt = 0; m_dout = 0; m_ovf = 0;
    end else begin
      do_rd = re && q.size() != 0;
      do_wr = we && q.size() != 16;
      if (we && q.size() == 16 && !re) m_ovf = 1;
      if (do_rd) begin
        e = q.pop_front();
        m_dout = e[7:0];
        m_pkt = e[8] ? int'(e[7:2]) + 1 : (m_pkt != 0 ? m_pkt - 1 : 0);
      end else if (m_pkt == 0) m_dout = 0;
      if (do_wr) q.push_back({lfd, d});
    end
    @(posedge clk); #1;
    chk("data_out", bus.data_out, m_dout);
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == 16);
    chk("pkt_cnt", dut.r_pkt_cnt, m_pkt);
`ifdef ROUTER_FIFO_OVF_EN
    chk("ovf_err", ovf, m_ovf);
`endif
  endtask
  task automatic wr(input logic lfd, input logic [7:0] d); step(0, 0, 1, 0, lfd, d); endtask
  task automatic rd(); step(0, 0, 0, 1, 0, 8'h00); endtask
  task automatic idle(); step(0, 0, 0, 0, 0, 8'h00); endtask
  initial begin
    step(1, 0, 1, 0, 1, 8'h0D);
    step(1, 0, 1, 0, 0, 8'h11);
    step(1, 0, 1, 0, 0, 8'h22);
    idle();
    idle();
    wr(1, 8'h0D); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h3F);
    for (int i = 0; i < 5; i++) rd();
    idle();
    for (int i = 0; i < 16; i++) wr(0, 8'(i * 7 + 3));
    wr(0, 8'hAA);
    for (int i = 0; i < 16; i++) rd();
    for (int i = 0; i < 16; i++) wr(0, 8'(i + 8'h60));
    step(0, 0, 1, 1, 0, 8'h55);
    chk("occupancy_after_rw_full", q.size(), 15);
    for (int i = 0; i < 15; i++) rd();
    idle();
    for (int i = 0; i < 10; i++) wr(0, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 12; i++) wr(0, 8'(8'hC0 + i));
    for (int i = 0; i < 12; i++) rd();
    idle();
    wr(1, 8'h14);
    for (int i = 0; i < 7; i++) wr(0, 8'(8'hE0 + i));
    rd(); rd();
    idle();
    step(0, 1, 0, 0, 0, 8'h00);
    rd();
    idle();
    for (int i = 0; i < 300; i++)
      step(0, ($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router.
- Sits downstream of the register stage: it captures that stage's 8-bit dout, tagged with the FSM's lfd_state header flag, and buffers it.
- Three instances exist, one per output port. Each is drained by its destination's read enable.
- It tracks packet boundaries from the header length field, so the read side knows when a packet has fully left.

Parameters:
- DEPTH, 16, number of 9-bit entries; must be a power of two.
- WIDTH, 8, data byte width.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- soft_reset  input  1  synchronous, active-high flush; asserted by the sync block on read timeout.
- write_enb  input  1  write request from the sync block for this port.
- read_enb  input  1  read request from the destination.
- lfd_state  input  1  marks data_in as a header byte; stored as entry bit 8.
- data_in  input  WIDTH  byte from the register stage.
- data_out  output  WIDTH  registered read data.
- empty  output  1  high when occupancy is 0.
- full  output  1  high when occupancy equals DEPTH.

Behaviour:
- Storage: DEPTH x (WIDTH+1) entries; bit 8 is the header tag.
- wr_ptr and rd_ptr are AW+1 bits; the extra MSB disambiguates wrap-around.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) and (wr_ptr[AW] != rd_ptr[AW]).
- empty and full are combinational from the pointers.
- Priority: reset, then soft_reset, then normal operation.
- reset or soft_reset, next edge:
  - pointers cleared.
  - data_out = 0.
  - pkt_cnt = 0.
  - all entries cleared to 0.
  - Therefore empty = 1, full = 0.
- Write: when write_enb && !full, mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr increments. A write while full is dropped and wr_ptr is unchanged.
- Read: when read_enb && !empty, rd_ptr increments and data_out <= mem[rd_ptr][7:0]. Latency is one cycle: data is valid on data_out the cycle after read_enb is sampled.
- Simultaneous read and write:
  - Each is gated only by its own flag, evaluated before the edge.
  - When full, the read proceeds and the write is dropped.
  - When empty, the write proceeds and the read is ignored.
  - Otherwise both proceed; occupancy is unchanged.
- Packet counter pkt_cnt, 7 bits:
  - Reading an entry with bit 8 = 1 loads pkt_cnt = mem[rd_ptr][7:2] + 1, i.e. payload length plus the parity byte.
  - Reading a non-header entry while pkt_cnt != 0 decrements pkt_cnt.
  - Reading a non-header entry while pkt_cnt == 0 leaves it at 0; the byte still outputs.
- data_out clearing: when pkt_cnt == 0 and no read occurs, data_out <= 0 on the next edge. This drives 0 between packets instead of stale data.
- data_out hold: while pkt_cnt != 0 and no read occurs, data_out holds its value.
- Wrap-around: pointer low bits wrap from DEPTH-1 to 0 and the MSB toggles. There is no special case at the wrap.
- Reset mid-packet: contents and counter are discarded. The next write must be a header.
- The block has no internal notion of packet validity beyond the tag bit.

Optional Feature:
- Macro: ROUTER_FIFO_OVF_EN.
- Defined:
  - Adds output port ovf_err (1 bit).
  - ovf_err sets when write_enb && full && !(read_enb) is sampled.
  - It is sticky until reset or soft_reset, and it resets to 0.
- Undefined: the port and its logic are absent, and dropped writes are silent.

Decomposition:
- Shared package router_pkg:
  - WIDTH = 8.
  - FIFO_DEPTH = 16.
  - HDR_LEN_MSB = 7 and HDR_LEN_LSB = 2 (header length field).
  - ADDR field bits [1:0], used elsewhere.
  - Parity-byte count constant, 1.
- One natural sub-module: router_fifo_ptr, a pointer pair with full/empty generation, reusable across the three instances.
- The packet counter stays in the top level.

Test Plan:
- Reset then idle -> empty = 1, full = 0, data_out = 0. Three writes during reset -> none stored; empty stays 1.
- Write header 0x0D (len 3, lfd = 1), then 0x11, 0x22, 0x33, then parity 0x3F; then read 5 times back-to-back ->
  - data_out = 0x0D, 0x11, 0x22, 0x33, 0x3F on successive cycles.
  - pkt_cnt goes 4, 3, 2, 1, 0.
  - data_out = 0 on the cycle after the last read.
- Write 16 bytes -> full = 1 after the 16th write. A 17th write of 0xAA is dropped. 16 reads return the original bytes, with no 0xAA.
- At full, assert read_enb and write_enb together with 0x55 -> one byte read, 0x55 dropped, occupancy 15, full = 0.
- Fill 10 bytes, read 10, then write and read 12 more (pointers wrap past 15) -> data order preserved; empty toggles correctly.
- Mid-packet soft_reset with 6 entries held -> next cycle: empty = 1, data_out = 0, pkt_cnt = 0.
- With ROUTER_FIFO_OVF_EN defined, the full-and-write case without read sets ovf_err = 1, and it holds until soft_reset.
